// File: rtl/lebug_pkg.sv
// lebug_pkg: shared config layout constants and firmware byte type for the trace path.
package lebug_pkg;
    localparam int CFG_COMMIT_OFS      = 0;
    localparam int CFG_SIZE_OFS        = 1;
    localparam int CFG_BYTES_PER_CHAIN = 2;
    typedef logic [7:0] firmware_byte_t;
endpackage

// File: rtl/pack_buffer.sv
// pack_buffer: packs kept input lanes behind the buffered lanes through a 2N-lane window.
module pack_buffer
    import lebug_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CW         = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    append_i,
    input  logic                    flush_i,
    input  logic [CW-1:0]           size_i,
    input  logic [N*DATA_WIDTH-1:0] vector_i,
    output logic                    emit_o,
    output logic [N*DATA_WIDTH-1:0] emit_vector_o,
    output logic [CW-1:0]           emit_count_o,
    output logic [CW-1:0]           count_o
);
    localparam int LW = N * DATA_WIDTH;
    localparam logic [CW:0] FULL = (CW + 1)'(N);

    logic [LW-1:0]   buffer_q, buffer_d, kept;
    logic [2*LW-1:0] window;
    logic [CW-1:0]   count_q, count_d;
    logic [CW:0]     total;
    logic            wrap;

    // Lanes above count_q are kept zero, so OR-ing the shifted input is a clean append.
    always_comb begin
        kept = '0;
        for (int i = 0; i < N; i++)
            kept[i*DATA_WIDTH +: DATA_WIDTH] = (append_i && i < int'(size_i)) ? vector_i[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        window        = ({{LW{1'b0}}, kept} << (int'(count_q) * DATA_WIDTH)) | {{LW{1'b0}}, buffer_q};
        total         = {1'b0, count_q} + (append_i ? {1'b0, size_i} : '0);
        wrap          = append_i && total >= FULL;
        emit_o        = flush_i | wrap;
        emit_vector_o = window[LW-1:0];
        emit_count_o  = flush_i ? count_q : CW'(N);
        buffer_d      = flush_i ? '0 : wrap ? window[2*LW-1:LW] : window[LW-1:0];
        count_d       = flush_i ? '0 : wrap ? CW'(total - FULL) : total[CW-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer_q <= '0;
            count_q  <= '0;
        end else begin
            buffer_q <= buffer_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/data_packer.sv
// data_packer: keeps the first size lanes of each committed beat and packs them into full N-lane vectors.
module data_packer
    import lebug_pkg::*;
#(
    parameter int             N                  = 8,
    parameter int             DATA_WIDTH         = 32,
    parameter int             MAX_CHAINS         = 4,
    parameter firmware_byte_t PERSONAL_CONFIG_ID = 8'd0,
    parameter firmware_byte_t INITIAL_FIRMWARE_COMMIT [0:MAX_CHAINS-1] = '{default: 8'd0},
    parameter firmware_byte_t INITIAL_FIRMWARE_SIZE   [0:MAX_CHAINS-1] = '{default: firmware_byte_t'(N)}
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tracing,
    input  logic                          valid_in,
    input  logic                          eof_in,
    input  logic                          bof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    input  logic [N*DATA_WIDTH-1:0]       vector_in,
    output logic [N*DATA_WIDTH-1:0]       vector_out,
    output logic                          valid_out,
    output logic [$clog2(N+1)-1:0]        count_out
);
    localparam int CW   = $clog2(N + 1);
    localparam int NCFG = CFG_BYTES_PER_CHAIN * MAX_CHAINS;

    firmware_byte_t          cfg_q [0:NCFG-1];
    firmware_byte_t          commit_c [0:MAX_CHAINS-1];
    firmware_byte_t          size_c [0:MAX_CHAINS-1];
    logic                    tracing_q, valid_out_q;
    logic [N*DATA_WIDTH-1:0] vector_out_q, emit_vector;
    logic [CW-1:0]           count_out_q, emit_count, buf_count, size_eff;
    logic                    accept, flush, cfg_wr, emit;
    logic                    unused_markers;

    always_comb begin
        for (int c = 0; c < MAX_CHAINS; c++) begin
            commit_c[c] = cfg_q[CFG_BYTES_PER_CHAIN*c + CFG_COMMIT_OFS];
            size_c[c]   = cfg_q[CFG_BYTES_PER_CHAIN*c + CFG_SIZE_OFS];
        end
    end

    assign accept         = tracing && valid_in && commit_c[chainId_in] != '0 && size_c[chainId_in] != '0;
    assign size_eff       = size_c[chainId_in] > firmware_byte_t'(N) ? CW'(N) : size_c[chainId_in][CW-1:0];
    assign flush          = tracing_q && !tracing && buf_count != '0;
    assign cfg_wr         = !tracing && configId == PERSONAL_CONFIG_ID;
    assign unused_markers = eof_in ^ bof_in;

    pack_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH), .CW(CW)) u_pack_buffer (
        .clk           (clk),
        .reset_n       (reset_n),
        .append_i      (accept),
        .flush_i       (flush),
        .size_i        (size_eff),
        .vector_i      (vector_in),
        .emit_o        (emit),
        .emit_vector_o (emit_vector),
        .emit_count_o  (emit_count),
        .count_o       (buf_count)
    );

    // Config bytes shift in from the top, so the first byte written ends up as chain 0's commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                cfg_q[CFG_BYTES_PER_CHAIN*c + CFG_COMMIT_OFS] <= INITIAL_FIRMWARE_COMMIT[c];
                cfg_q[CFG_BYTES_PER_CHAIN*c + CFG_SIZE_OFS]   <= INITIAL_FIRMWARE_SIZE[c];
            end
            tracing_q    <= 1'b0;
            valid_out_q  <= 1'b0;
            vector_out_q <= '0;
            count_out_q  <= '0;
        end else begin
            if (cfg_wr) begin
                for (int k = 0; k < NCFG - 1; k++) cfg_q[k] <= cfg_q[k+1];
                cfg_q[NCFG-1] <= configData;
            end
            tracing_q   <= tracing;
            valid_out_q <= emit;
            if (emit) begin
                vector_out_q <= emit_vector;
                count_out_q  <= emit_count;
            end
        end
    end

    assign vector_out = vector_out_q;
    assign valid_out  = valid_out_q;
    assign count_out  = count_out_q;
endmodule

// File: tb/tb_data_packer.sv
// tb_data_packer: directed vector table, reset/flush sequences and a queue-based random reference check.
module tb_data_packer;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         tracing = 1'b0, valid_in = 1'b0, eof_in = 1'b0, bof_in = 1'b0;
    logic [1:0]   chainId_in = '0;
    logic [7:0]   configId = 8'hFF, configData = '0;
    logic [255:0] vector_in = '0, vector_out;
    logic         valid_out;
    logic [3:0]   count_out;
    int           n_cmp = 0, n_err = 0;

    data_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tracing    (tracing),
        .valid_in   (valid_in),
        .eof_in     (eof_in),
        .bof_in     (bof_in),
        .chainId_in (chainId_in),
        .configId   (configId),
        .configData (configData),
        .vector_in  (vector_in),
        .vector_out (vector_out),
        .valid_out  (valid_out),
        .count_out  (count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         tr, v;
        logic [1:0]   ch;
        logic [255:0] vec;
        logic [7:0]   cid, cd;
        logic         ev;
        logic [3:0]   ec;
        logic [255:0] evec;
    } row_t;
    row_t rows [17];

    logic [7:0]  m_cfg [8];
    logic [31:0] m_q [$];
    logic        m_prev, m_valid;
    logic [3:0]  m_cnt;
    logic [255:0] m_vec;

    function automatic logic [255:0] v8(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7);
        return {32'(a7), 32'(a6), 32'(a5), 32'(a4), 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    task automatic apply(input logic tr, v, input logic [1:0] ch, input logic [255:0] vec, input logic [7:0] cid, cd);
        tracing = tr; valid_in = v; chainId_in = ch; vector_in = vec; configId = cid; configData = cd;
        eof_in = $urandom_range(0, 1) == 1; bof_in = $urandom_range(0, 1) == 1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic ev, input logic [3:0] ec, input logic [255:0] evec);
        n_cmp++;
        if (valid_out !== ev || count_out !== ec || vector_out !== evec) begin
            n_err++;
            $display("FAIL %s: got valid=%0b count=%0d vec=%h, required valid=%0b count=%0d vec=%h",
                     nm, valid_out, count_out, vector_out, ev, ec, evec);
        end
    endtask

    task automatic model_reset();
        m_cfg = '{8'd0, 8'd8, 8'd0, 8'd8, 8'd0, 8'd8, 8'd0, 8'd8};
        m_q.delete();
        m_prev = 0; m_valid = 0; m_cnt = 0; m_vec = '0;
    endtask

    // Reference: a FIFO of kept elements; every N accumulated elements form one output vector.
    task automatic model_step(input logic tr, v, input logic [1:0] ch, input logic [255:0] vec, input logic [7:0] cid, cd);
        int s;
        m_valid = 0;
        if (tr && v && m_cfg[2*ch] != 0 && m_cfg[2*ch+1] != 0) begin
            s = m_cfg[2*ch+1] > 8 ? 8 : int'(m_cfg[2*ch+1]);
            for (int i = 0; i < s; i++) m_q.push_back(vec[i*32 +: 32]);
            if (m_q.size() >= 8) begin
                m_valid = 1; m_cnt = 8;
                for (int i = 0; i < 8; i++) m_vec[i*32 +: 32] = m_q.pop_front();
            end
        end else if (m_prev && !tr && m_q.size() > 0) begin
            m_valid = 1; m_cnt = 4'(m_q.size()); m_vec = '0;
            for (int i = 0; m_q.size() > 0; i++) m_vec[i*32 +: 32] = m_q.pop_front();
        end
        if (!tr && cid == 0) begin
            for (int k = 0; k < 7; k++) m_cfg[k] = m_cfg[k+1];
            m_cfg[7] = cd;
        end
        m_prev = tr;
    endtask

    task automatic cycle(input string nm, input logic tr, v, input logic [1:0] ch, input logic [255:0] vec, input logic [7:0] cid, cd);
        model_step(tr, v, ch, vec, cid, cd);
        apply(tr, v, ch, vec, cid, cd);
        chk(nm, m_valid, m_cnt, m_vec);
    endtask

    initial begin
        logic [7:0]   cfg_bytes [8];
        logic [255:0] rv, full8, wrap1, wrap2, fl1, fl2;
        cfg_bytes = '{8'd1, 8'd8, 8'd1, 8'd2, 8'd1, 8'd3, 8'd0, 8'd8};
        full8 = v8(1, 2, 3, 4, 5, 6, 7, 8);
        wrap1 = v8(10, 11, 12, 20, 21, 22, 30, 31);
        wrap2 = v8(32, 40, 41, 42, 50, 51, 60, 61);
        fl1   = v8(62, 63, 64, 65, 66, 67, 0, 0);
        fl2   = v8(70, 71, 0, 0, 0, 0, 0, 0);
        // chains: 0 size 8, 1 size 2, 2 size 3, 3 uncommitted
        rows[0]  = '{1, 0, 0, '0, 8'hFF, 0, 0, 0, '0};
        rows[1]  = '{1, 1, 0, full8, 8'hFF, 0, 1, 8, full8};
        rows[2]  = '{1, 1, 2, v8(10, 11, 12, 99, 99, 99, 99, 99), 8'hFF, 0, 0, 8, full8};
        rows[3]  = '{1, 1, 2, v8(20, 21, 22, 98, 98, 98, 98, 98), 8'hFF, 0, 0, 8, full8};
        rows[4]  = '{1, 1, 3, v8(77, 77, 77, 77, 77, 77, 77, 77), 8'hFF, 0, 0, 8, full8};
        rows[5]  = '{1, 1, 2, v8(30, 31, 32, 97, 97, 97, 97, 97), 8'hFF, 0, 1, 8, wrap1};
        rows[6]  = '{1, 0, 2, v8(88, 88, 88, 88, 88, 88, 88, 88), 8'hFF, 0, 0, 8, wrap1};
        rows[7]  = '{1, 1, 2, v8(40, 41, 42, 96, 96, 96, 96, 96), 8'hFF, 0, 0, 8, wrap1};
        rows[8]  = '{1, 1, 1, v8(50, 51, 95, 95, 95, 95, 95, 95), 8'hFF, 0, 0, 8, wrap1};
        rows[9]  = '{1, 1, 0, v8(60, 61, 62, 63, 64, 65, 66, 67), 8'hFF, 0, 1, 8, wrap2};
        rows[10] = '{0, 1, 0, full8, 8'hFF, 0, 1, 6, fl1};
        rows[11] = '{0, 0, 0, '0, 8'hFF, 0, 0, 6, fl1};
        rows[12] = '{1, 1, 1, v8(70, 71, 94, 94, 94, 94, 94, 94), 8'hFF, 0, 0, 6, fl1};
        rows[13] = '{0, 0, 0, '0, 8'hFF, 0, 1, 2, fl2};
        rows[14] = '{1, 0, 0, '0, 8'h00, 0, 0, 2, fl2};
        rows[15] = '{1, 1, 0, full8, 8'hFF, 0, 1, 8, full8};
        rows[16] = '{0, 0, 0, '0, 8'hFF, 0, 0, 8, full8};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 0, 0, '0);
        reset_n = 1'b1;
        foreach (cfg_bytes[i]) apply(0, 0, 0, '0, 8'h00, cfg_bytes[i]);
        chk("after_config", 0, 0, '0);

        for (int i = 0; i < 17; i++) begin
            apply(rows[i].tr, rows[i].v, rows[i].ch, rows[i].vec, rows[i].cid, rows[i].cd);
            chk($sformatf("row%0d", i), rows[i].ev, rows[i].ec, rows[i].evec);
        end

        // Reset mid-pack with five elements buffered and valid_out high.
        apply(1, 1, 2, v8(1, 2, 3, 9, 9, 9, 9, 9), 8'hFF, 0);
        apply(1, 1, 1, v8(4, 5, 9, 9, 9, 9, 9, 9), 8'hFF, 0);
        apply(1, 1, 0, v8(11, 12, 13, 14, 15, 16, 17, 18), 8'hFF, 0);
        chk("pre_reset_emit", 1, 8, v8(1, 2, 3, 4, 5, 11, 12, 13));
        valid_in = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 0, 0, '0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        apply(1, 1, 0, full8, 8'hFF, 0);
        chk("initial_commit_off", 0, 0, '0);
        foreach (cfg_bytes[i]) apply(0, 0, 0, '0, 8'h00, cfg_bytes[i]);
        chk("no_flush_after_reset", 0, 0, '0);
        apply(1, 1, 0, full8, 8'hFF, 0);
        chk("post_reset_fresh", 1, 8, full8);

        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) cycle("rand_cfg", 0, 0, 0, '0, 8'h00, 8'($urandom_range(1, 10)));
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 8; i++) rv[i*32 +: 32] = $urandom;
            cycle($sformatf("rand%0d", n), $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), rv, $urandom_range(0, 1) == 1 ? 8'h00 : 8'h03,
                  8'($urandom_range(0, 10)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_packer.md
# data_packer

Trace-path stage directly downstream of the vector-vector ALU and upstream of the trace buffer. Per chain, it keeps the first `size` elements of each committed input vector, drops the rest, and packs the kept elements contiguously into full N-element output vectors. Packing stops the trace buffer from spending a full N-wide slot on a reduced result, such as a scalar sitting in lane 0. A partially filled pack is flushed, zero-padded, when tracing stops.

## Interface
- `N`, 8, lanes per vector
- `DATA_WIDTH`, 32, bits per element
- `MAX_CHAINS`, 4, number of firmware chains
- `PERSONAL_CONFIG_ID`, 0, `configId` value addressing this block
- `INITIAL_FIRMWARE_COMMIT`, all 0, per-chain commit enable (byte array `[0:MAX_CHAINS-1]`)
- `INITIAL_FIRMWARE_SIZE`, all N, per-chain kept-element count (byte array)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `tracing`  in  1  tracing enabled
- `valid_in`  in  1  input vector valid
- `eof_in`, `bof_in`  in  1  frame markers (ignored for packing)
- `chainId_in`  in  clog2(MAX_CHAINS)  chain of input vector
- `configId`  in  8  config target id
- `configData`  in  8  config byte
- `vector_in`  in  N×DATA_WIDTH  input lanes
- `vector_out`  out  N×DATA_WIDTH  packed lanes, lane 0 is the oldest element
- `valid_out`  out  1  one-cycle pulse per packed vector
- `count_out`  out  clog2(N+1)  valid lanes in `vector_out` (N except on flush)

## Operation
**Reset.** All outputs are 0, the pack buffer is empty (count = 0), and the firmware registers load their INITIAL_* values.

**Configuration.**
- A config write occurs when `tracing==0` and `configId==PERSONAL_CONFIG_ID`.
- The cfg array `[0:2*MAX_CHAINS-1]` shifts down one byte: `cfg[k]<=cfg[k+1]`, and `cfg[last]<=configData`.
- `cfg[2c]` is commit for chain c; `cfg[2c+1]` is size for chain c.
- Host writes 2*MAX_CHAINS bytes, starting with chain 0's commit byte.
- Config writes are ignored while `tracing==1`.

**Accept.** An input beat is accepted when `tracing && valid_in && commit[chainId_in]!=0 && size[chainId_in]!=0`.
- Effective size s = min(size, N).
- The kept elements are `vector_in[0..s-1]`, taken in lane order.

**Packing.** Let c be the current buffer count (0..N-1) and t = c+s.
- If t<N: append the s elements and set count=t. No output.
- If t≥N: emit the buffer elements followed by `vector_in[0..N-c-1]`, with `count_out=N`. The remaining t-N elements `vector_in[N-c..s-1]` go to buffer lanes 0.., and count=t-N.

**Flush.**
- Triggered on the `tracing` 1→0 edge, detected from a registered copy of `tracing`, when c>0.
- Emits the buffer in lanes 0..c-1 with zeros above, sets `count_out=c`, and empties the buffer.
- If c==0, nothing is emitted.

**Other rules.**
- Beats that are not accepted have no effect.
- No backpressure: the downstream stage always accepts.

## Timing
- Latency is 1 cycle: the accepted beat or flush edge at cycle k produces `valid_out` at k+1.
- `valid_out` is high for exactly one cycle per emission.
- `vector_out` and `count_out` hold their last value when `valid_out==0`.
- Accepted beats may arrive every cycle. Throughput is one output per cycle max; each beat produces at most one output, since s≤N means at most one wrap.
- Buffer state after a beat is usable by a beat in the very next cycle; there are no bubbles.
- An input beat is impossible in the flush cycle because `tracing==0`, so no simultaneous accept and flush.
- Reset asserted mid-pack discards buffered elements with no output and clears `valid_out` immediately (asynchronous).
- A config write while c>0 takes effect from the next accepted beat; buffered data is unaffected.

## Structure
- Shared package `lebug_pkg`:
  - `CFG_COMMIT_OFS=0`, `CFG_SIZE_OFS=1`, `CFG_BYTES_PER_CHAIN=2`.
  - Typedef `firmware_byte_t` (logic [7:0]).
- One sub-module, `pack_buffer`: holds buffer lanes and count, and has append/emit/flush inputs. It is implemented as a 2N-lane window (buffer concatenated with the aligned input) indexed by c. The top level holds config, the accept decode, flush edge detection and output registers.

## Test plan
N=8, DATA_WIDTH=32, MAX_CHAINS=4.
- Reset: assert `reset_n=0` mid-run with 5 elements buffered -> `valid_out=0`, `count_out=0`; after release, an 8-wide beat emits only the new data.
- Full-width: chain 0 commit=1, size=8, beat `vector_in`={1..8} -> next cycle `valid_out=1`, `vector_out`={1..8}, `count_out=8`.
- Wrap: chain 1 size=3, four back-to-back beats {10,11,12}, {20,21,22}, {30,31,32}, {40,41,42} -> single output after beat 3 = {10,11,12,20,21,22,30,31}; final buffer {32,40,41,42}, count 4.
- Filtering: chain 2 commit=0, or size=0, valid beats -> no output and buffer unchanged; an interleaved chain 0 beat still emits.
- Flush: 5 elements {1..5} buffered, drop `tracing` -> one pulse with {1,2,3,4,5,0,0,0}, `count_out=5`; a second tracing drop emits nothing.
- Config: with `tracing=0`, write bytes 1,8,1,2,1,3,0,8 -> chains 0..2 committed with sizes 8,2,3, chain 3 off. Writes with `tracing=1` change nothing.
